// File: rtl/flash_spi_target.sv
// SPI NOR-flash responder (mode 0, MSB first) serving a small byte array.
// SPI pins are oversampled on i_clk; SCLK must be at most i_clk/8.
module flash_spi_target #(
    parameter int          ADDR_W   = 8,
    parameter logic [23:0] JEDEC_ID = 24'hEF4017
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_flash_cs,
    input  logic       i_flash_clk,
    input  logic       i_flash_din,
    output logic       o_flash_dout,
    output logic       o_busy,
    output logic       o_cmd_valid,
    output logic [7:0] o_cmd
);

    typedef enum logic [2:0] {
        T_IDLE, T_CMD, T_ADDR, T_READ,
        T_PROG, T_STAT, T_ID, T_IGNORE
    } state_t;

    typedef enum logic [1:0] {OP_READ, OP_PROG, OP_ERASE} op_t;

    localparam int DEPTH = 1 << ADDR_W;
    localparam int SR_W  = (ADDR_W > 8) ? ADDR_W : 8;
    localparam logic [ADDR_W-1:0] A_ONE = 1;

    logic [7:0] mem [DEPTH];

    logic [1:0] cs_sync, ck_sync, di_sync;
    logic       cs_prev, ck_prev;
    logic       cs_s, ck_s, di_s;
    logic       ck_rise, ck_fall, cs_rise, cs_fall;

    state_t            state, state_d;
    op_t               op, op_d;
    logic [2:0]        bit_cnt, bit_cnt_d;
    logic [1:0]        byte_cnt, byte_cnt_d;
    logic [1:0]        id_idx, id_idx_d;
    logic [SR_W-2:0]   sr, sr_d;
    logic [SR_W-1:0]   word;
    logic [6:0]        sh_out, sh_out_d;
    logic              dout_d;
    logic [ADDR_W-1:0] addr, addr_d;
    logic [ADDR_W-1:0] er_addr, er_addr_d;
    logic              wel, wel_d;
    logic              wel_clr, wel_clr_d;
    logic              armed, armed_d;
    logic              busy_d;
    logic              cmd_valid_d;
    logic [7:0]        cmd_d;
    logic              prog_we;
    logic [7:0]        rd_byte, tx_byte, id_byte;

    assign cs_s    = cs_sync[1];
    assign ck_s    = ck_sync[1];
    assign di_s    = di_sync[1];
    assign ck_rise = ck_s & ~ck_prev;
    assign ck_fall = ~ck_s & ck_prev;
    assign cs_rise = cs_s & ~cs_prev;
    assign cs_fall = ~cs_s & cs_prev;
    assign word    = {sr, di_s};
    assign rd_byte = mem[addr];

    always_comb begin
        case (id_idx)
            2'd0:    id_byte = JEDEC_ID[23:16];
            2'd1:    id_byte = JEDEC_ID[15:8];
            default: id_byte = JEDEC_ID[7:0];
        endcase
    end

    always_comb begin
        state_d     = state;
        op_d        = op;
        bit_cnt_d   = bit_cnt;
        byte_cnt_d  = byte_cnt;
        id_idx_d    = id_idx;
        sr_d        = sr;
        sh_out_d    = sh_out;
        dout_d      = o_flash_dout;
        addr_d      = addr;
        er_addr_d   = er_addr;
        wel_d       = wel;
        wel_clr_d   = wel_clr;
        armed_d     = armed;
        busy_d      = o_busy;
        cmd_valid_d = 1'b0;
        cmd_d       = o_cmd;
        prog_we     = 1'b0;
        tx_byte     = 8'hFF;

        if (o_busy) begin
            er_addr_d = er_addr + A_ONE;
            if (&er_addr) busy_d = 1'b0;
        end

        if (cs_s) begin
            state_d    = T_IDLE;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            dout_d     = 1'b1;
            sh_out_d   = '1;
            armed_d    = 1'b0;
            if (cs_rise) begin
                // erase decision uses WEL before the end-of-transaction clear
                if (armed && wel && !o_busy) begin
                    busy_d    = 1'b1;
                    er_addr_d = '0;
                end
                if (wel_clr) wel_d = 1'b0;
                wel_clr_d = 1'b0;
            end
        end else if (state == T_IDLE) begin
            if (cs_fall) state_d = T_CMD;
        end else if (ck_rise) begin
            bit_cnt_d = bit_cnt + 3'd1;
            sr_d      = word[SR_W-2:0];
            case (state)
                T_CMD: begin
                    if (bit_cnt == 3'd7) begin
                        cmd_valid_d = 1'b1;
                        cmd_d       = word[7:0];
                        byte_cnt_d  = '0;
                        id_idx_d    = '0;
                        if (word[7:0] == 8'h02 || word[7:0] == 8'h20)
                            wel_clr_d = 1'b1;
                        if (o_busy && word[7:0] != 8'h05) begin
                            state_d = T_IGNORE;
                        end else begin
                            case (word[7:0])
                                8'h06: begin
                                    wel_d   = 1'b1;
                                    state_d = T_IGNORE;
                                end
                                8'h04: begin
                                    wel_d   = 1'b0;
                                    state_d = T_IGNORE;
                                end
                                8'h05: state_d = T_STAT;
                                8'h9F: state_d = T_ID;
                                8'h03: begin
                                    state_d = T_ADDR;
                                    op_d    = OP_READ;
                                end
                                8'h02: begin
                                    state_d = T_ADDR;
                                    op_d    = OP_PROG;
                                end
                                8'h20: begin
                                    state_d = T_ADDR;
                                    op_d    = OP_ERASE;
                                end
                                default: state_d = T_IGNORE;
                            endcase
                        end
                    end
                end
                T_ADDR: begin
                    // any bit beyond the 32nd disqualifies an armed erase
                    if (armed) begin
                        armed_d = 1'b0;
                        state_d = T_IGNORE;
                    end else if (bit_cnt == 3'd7) begin
                        byte_cnt_d = byte_cnt + 2'd1;
                        if (byte_cnt == 2'd2) begin
                            addr_d = word[ADDR_W-1:0];
                            case (op)
                                OP_READ: state_d = T_READ;
                                OP_PROG: state_d = T_PROG;
                                default: armed_d = 1'b1;
                            endcase
                        end
                    end
                end
                T_PROG: begin
                    if (bit_cnt == 3'd7) begin
                        prog_we = wel;
                        addr_d  = addr + A_ONE;
                    end
                end
                default: ;
            endcase
        end else if (ck_fall) begin
            if (bit_cnt == 3'd0) begin
                case (state)
                    T_READ: begin
                        tx_byte = rd_byte;
                        addr_d  = addr + A_ONE;
                    end
                    T_STAT: tx_byte = {6'b0, wel, o_busy};
                    T_ID: begin
                        tx_byte  = id_byte;
                        id_idx_d = (id_idx == 2'd2) ? 2'd0 : id_idx + 2'd1;
                    end
                    default: tx_byte = 8'hFF;
                endcase
                dout_d   = tx_byte[7];
                sh_out_d = tx_byte[6:0];
            end else begin
                dout_d   = sh_out[6];
                sh_out_d = {sh_out[5:0], 1'b1};
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cs_sync      <= 2'b11;
            ck_sync      <= 2'b00;
            di_sync      <= 2'b00;
            cs_prev      <= 1'b1;
            ck_prev      <= 1'b0;
            state        <= T_IDLE;
            op           <= OP_READ;
            bit_cnt      <= '0;
            byte_cnt     <= '0;
            id_idx       <= '0;
            sr           <= '0;
            sh_out       <= '1;
            o_flash_dout <= 1'b1;
            addr         <= '0;
            er_addr      <= '0;
            wel          <= 1'b0;
            wel_clr      <= 1'b0;
            armed        <= 1'b0;
            o_busy       <= 1'b0;
            o_cmd_valid  <= 1'b0;
            o_cmd        <= 8'h00;
        end else begin
            cs_sync      <= {cs_sync[0], i_flash_cs};
            ck_sync      <= {ck_sync[0], i_flash_clk};
            di_sync      <= {di_sync[0], i_flash_din};
            cs_prev      <= cs_s;
            ck_prev      <= ck_s;
            state        <= state_d;
            op           <= op_d;
            bit_cnt      <= bit_cnt_d;
            byte_cnt     <= byte_cnt_d;
            id_idx       <= id_idx_d;
            sr           <= sr_d;
            sh_out       <= sh_out_d;
            o_flash_dout <= dout_d;
            addr         <= addr_d;
            er_addr      <= er_addr_d;
            wel          <= wel_d;
            wel_clr      <= wel_clr_d;
            armed        <= armed_d;
            o_busy       <= busy_d;
            o_cmd_valid  <= cmd_valid_d;
            o_cmd        <= cmd_d;
        end
    end

    // single write port: erase sweep and program never overlap
    always_ff @(posedge i_clk) begin
        if (o_busy)
            mem[er_addr] <= 8'hFF;
        else if (prog_we)
            mem[addr] <= rd_byte & word[7:0];
    end

endmodule
